cute_key_sequencer: RTL and testbench
=====================================

Name: cute_key_sequencer

Overview:
- Key-provider end of the time-varying key interface used by our Cute-Lock encrypted FSM benchmarks.
- Holds NUM_KEYS keys, loaded once over a serial port from the secure key store.
- Replays the keys on the keyinput bus in lock-step with the locked FSM's internal epoch counter: key k during counter window [k*SEG_LEN, (k+1)*SEG_LEN-1], wrapping every NUM_KEYS*SEG_LEN cycles.
- Emits a one-cycle lock_rst pulse that aligns the locked block's counter with its own.

Parameters:
- KEY_W, 6: width of one key in bits (= number of keyinput pins).
- NUM_KEYS, 2: number of keys in the schedule.
- SEG_LEN, 6: clock cycles each key is held; epoch = NUM_KEYS*SEG_LEN (12).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous zeroize; same effect as rst.
- key_sin  in  1  serial key bit.
- key_sin_valid  in  1  key_sin is valid this cycle.
- start  in  1  begin replay; honoured only in ARMED.
- stop  in  1  end replay; honoured only in RUN.
- key_out  out  KEY_W  drives keyinput[KEY_W-1:0] of the locked block.
- key_valid  out  1  high while key_out carries a scheduled key (RUN).
- lock_rst  out  1  one-cycle reset pulse to the locked block.
- seg_idx  out  clog2(NUM_KEYS)  index of the key currently driven.
- armed  out  1  all keys loaded, not running.

Behaviour:
- Reset and clear (clear has the same priority as rst):
  - State goes to IDLE. Key registers, bit counter, epoch counter and all outputs are set to 0.
  - Mid-RUN, key_out drops to 0 on the next cycle. No lock_rst pulse is generated.
- States:
  - IDLE: key_sin_valid=1 stores the bit, bitcnt becomes 1, go to LOAD.
  - LOAD: each key_sin_valid stores one bit. Serial bit n goes to key[n/KEY_W] bit (n%KEY_W); bit 0 is the first received.
  - LOAD to ARMED: on the cycle the final bit (n = NUM_KEYS*KEY_W-1) is stored. Gaps in key_sin_valid are allowed.
  - ARMED: armed=1. Further key_sin_valid is ignored (keys are write-once until clear). start=1 goes to RUN.
  - RUN: stop=1 goes to ARMED.
  - start in IDLE or LOAD, and stop outside RUN, are ignored.
- Entry to RUN (cycle 0 = first cycle in RUN):
  - lock_rst=1 for exactly cycle 0.
  - cnt=0, key_valid=1, key_out=key[0], seg_idx=0.
- In RUN:
  - cnt increments every cycle and wraps from NUM_KEYS*SEG_LEN-1 to 0.
  - seg_idx = cnt / SEG_LEN.
  - key_out = key[seg_idx], registered so it changes on the same edge as cnt.
- Alignment with the locked block:
  - The locked block samples keys on the falling edge, using its own counter value before that edge's increment.
  - lock_rst clears that counter, so on every falling edge its counter equals our cnt, which gives half a cycle of setup.
- Leaving RUN (stop): key_out=0, key_valid=0, cnt=0, armed=1 from the next cycle. A new start pulses lock_rst again.
- start and stop together in ARMED: start wins. In RUN: stop wins.
- A key value of 0 is legal and is not treated specially.
- Widths: bitcnt is clog2(NUM_KEYS*KEY_W+1) bits; cnt is clog2(NUM_KEYS*SEG_LEN) bits. No overflow is possible.

Decomposition:
- Shared package cute_lock_pkg holds:
  - the state enum {IDLE, LOAD, ARMED, RUN};
  - default KEY_W / NUM_KEYS / SEG_LEN constants, reused by the encrypted benchmarks;
  - a function key_of_seg(cnt) returning cnt/SEG_LEN.
- One sub-module, cute_key_shiftreg: the serial-load key store (write-once, zeroizable), exposing the flat NUM_KEYS*KEY_W vector and a load_done flag.
- The FSM and epoch counter stay in the top level.

Test Plan:
- Load stream 1,0,1,1,1,1,0,1,0,0,1,1 (with a 3-cycle valid gap mid-stream) -> armed=1 the cycle after the 12th bit; key[0]=6'b111101, key[1]=6'b110010.
- Start after the load above -> lock_rst=1 for one cycle only; key_out=6'b111101 for cycles 0-5, 6'b110010 for cycles 6-11, 6'b111101 again at cycle 12; seg_idx follows 0/1.
- Connect to girl10 with x6=1 held -> locked FSM reaches s2 and outputs y8=y9=1, matching the unencrypted reference FSM for 3 full epochs.
- stop at cnt=4, then start 2 cycles later -> key_out=0 and key_valid=0 while stopped; a new lock_rst pulse; restart at cnt=0 with key_out=key[0].
- rst asserted at cnt=8 in RUN -> next cycle IDLE, key_out=0, armed=0; start ignored until a full reload.
- start while in LOAD after 7 bits, plus 14 extra key_sin_valid bits in ARMED -> no RUN entry during LOAD; keys unchanged after the extra bits; bit 12 onward ignored.

Source files
------------

// File: rtl/cute_lock_pkg.sv
// Shared types and defaults for the Cute-Lock key interface and benchmarks.
package cute_lock_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, ARMED, RUN} state_t;

  localparam int DEF_KEY_W    = 6;
  localparam int DEF_NUM_KEYS = 2;
  localparam int DEF_SEG_LEN  = 6;

  // Which key segment a given epoch-counter value falls in.
  function automatic int unsigned key_of_seg(input int unsigned cnt,
                                             input int unsigned seg_len = DEF_SEG_LEN);
    return cnt / seg_len;
  endfunction

endpackage

// File: rtl/cute_key_shiftreg.sv
// Serial-load key store: write-once after reset/zeroize, bit 0 received first.
module cute_key_shiftreg
  import cute_lock_pkg::*;
#(
  parameter int KEY_W    = DEF_KEY_W,
  parameter int NUM_KEYS = DEF_NUM_KEYS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      bit_in,
  input  logic                      bit_valid,
  output logic [NUM_KEYS*KEY_W-1:0] keys,
  output logic                      load_done
);

  localparam int TOTAL = NUM_KEYS * KEY_W;
  localparam int CNT_W = $clog2(TOTAL + 1);

  logic [CNT_W-1:0] bitcnt;
  logic             full;
  logic             take;

  assign full = (bitcnt == CNT_W'(TOTAL));
  assign take = bit_valid && !full;
  // High on the cycle the last bit is taken, so the FSM arms on that same edge.
  assign load_done = full || (take && (bitcnt == CNT_W'(TOTAL - 1)));

  // Store each accepted bit at the position given by the running bit count.
  always_ff @(posedge clk) begin
    if (rst) begin
      bitcnt <= '0;
      keys   <= '0;
    end else if (take) begin
      for (int i = 0; i < TOTAL; i++)
        if (bitcnt == CNT_W'(i)) keys[i] <= bit_in;
      bitcnt <= bitcnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cute_key_sequencer.sv
// Key provider for Cute-Lock: loads keys serially, then replays them per epoch segment.
module cute_key_sequencer
  import cute_lock_pkg::*;
#(
  parameter  int KEY_W    = DEF_KEY_W,
  parameter  int NUM_KEYS = DEF_NUM_KEYS,
  parameter  int SEG_LEN  = DEF_SEG_LEN,
  localparam int SEG_W    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             key_sin,
  input  logic             key_sin_valid,
  input  logic             start,
  input  logic             stop,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             lock_rst,
  output logic [SEG_W-1:0] seg_idx,
  output logic             armed
);

  localparam int EPOCH = NUM_KEYS * SEG_LEN;
  localparam int CNT_W = (EPOCH > 1) ? $clog2(EPOCH) : 1;

  state_t                          state, state_d;
  logic [CNT_W-1:0]                cnt, cnt_d, cnt_inc;
  logic [KEY_W-1:0]                key_d;
  logic                            lock_rst_d;
  logic [NUM_KEYS*KEY_W-1:0]       keys_flat;
  logic [NUM_KEYS-1:0][KEY_W-1:0]  key_arr;
  logic                            load_done;
  logic                            zero;

  assign zero    = rst | clear;
  assign key_arr = keys_flat;

  cute_key_shiftreg #(.KEY_W(KEY_W), .NUM_KEYS(NUM_KEYS)) u_store (
    .clk       (clk),
    .rst       (zero),
    .bit_in    (key_sin),
    .bit_valid (key_sin_valid),
    .keys      (keys_flat),
    .load_done (load_done)
  );

  assign cnt_inc = (cnt == CNT_W'(EPOCH - 1)) ? '0 : cnt + CNT_W'(1);

  // Next state plus next epoch counter / key / lock_rst values.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    key_d      = key_out;
    lock_rst_d = 1'b0;
    case (state)
      IDLE:  if (key_sin_valid) state_d = load_done ? ARMED : LOAD;
      LOAD:  if (load_done) state_d = ARMED;
      ARMED: if (start) begin
        state_d    = RUN;
        cnt_d      = '0;
        key_d      = key_arr[0];
        lock_rst_d = 1'b1;
      end
      RUN: if (stop) begin
        state_d = ARMED;
        cnt_d   = '0;
        key_d   = '0;
      end else begin
        cnt_d = cnt_inc;
        key_d = key_arr[SEG_W'(key_of_seg(32'(cnt_inc), SEG_LEN))];
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; clear zeroizes exactly like rst.
  always_ff @(posedge clk) begin
    if (zero) state <= IDLE;
    else      state <= state_d;
  end

  // Registered key output so it moves on the same edge as the counter.
  always_ff @(posedge clk) begin
    if (zero) begin
      cnt      <= '0;
      key_out  <= '0;
      lock_rst <= 1'b0;
    end else begin
      cnt      <= cnt_d;
      key_out  <= key_d;
      lock_rst <= lock_rst_d;
    end
  end

  assign key_valid = (state == RUN);
  assign armed     = (state == ARMED);
  assign seg_idx   = SEG_W'(key_of_seg(32'(cnt), SEG_LEN));

endmodule

// File: tb/tb_cute_key_sequencer.sv
// Directed scoreboard bench for cute_key_sequencer (6-bit keys, 2 keys, 6-cycle segments).
module tb_cute_key_sequencer;

  logic       clk = 1'b0;
  logic       rst, clear, key_sin, key_sin_valid, start, stop;
  logic [5:0] key_out;
  logic       key_valid, lock_rst, armed;
  logic [0:0] seg_idx;

  cute_key_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .key_sin       (key_sin),
    .key_sin_valid (key_sin_valid),
    .start         (start),
    .stop          (stop),
    .key_out       (key_out),
    .key_valid     (key_valid),
    .lock_rst      (lock_rst),
    .seg_idx       (seg_idx),
    .armed         (armed)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [5:0] key;
    logic       kv;
    logic       lr;
    logic       arm;
    logic       seg;
  } exp_t;

  exp_t       sb[$];
  int         checks   = 0;
  int         failures = 0;
  logic [5:0] k0, k1;

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(string t, logic [5:0] k, logic kv, logic lr, logic arm, logic seg);
    exp_t e;
    e.tag = t; e.key = k; e.kv = kv; e.lr = lr; e.arm = arm; e.seg = seg;
    return e;
  endfunction

  function automatic exp_t idle_e(string t);
    return mk(t, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic exp_t arm_e(string t);
    return mk(t, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
  endfunction

  // Expected outputs at RUN cycle c (c=0 is the first cycle in RUN).
  function automatic exp_t run_e(string t, int c, logic lr);
    logic s;
    s = ((c % 12) >= 6);
    return mk(t, s ? k1 : k0, 1'b1, lr, 1'b0, s);
  endfunction

  // Apply currently driven inputs for one edge, then check the scoreboard entry.
  task automatic step(input exp_t e);
    exp_t x;
    sb.push_back(e);
    @(posedge clk);
    #1;
    rst = 0; clear = 0; key_sin = 0; key_sin_valid = 0; start = 0; stop = 0;
    @(negedge clk);
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      x = sb.pop_front();
      chk({x.tag, ".key_out"},   key_out,            x.key);
      chk({x.tag, ".key_valid"}, {5'd0, key_valid},  {5'd0, x.kv});
      chk({x.tag, ".lock_rst"},  {5'd0, lock_rst},   {5'd0, x.lr});
      chk({x.tag, ".armed"},     {5'd0, armed},      {5'd0, x.arm});
      chk({x.tag, ".seg_idx"},   {5'd0, seg_idx},    {5'd0, x.seg});
    end
  endtask

  // Serial load of 12 bits; optional gap after 7 bits with start held high.
  task automatic load(input logic [11:0] bits, input int gap_len);
    for (int n = 0; n < 12; n++) begin
      key_sin = bits[n];
      key_sin_valid = 1;
      if (n == 11) step(arm_e($sformatf("load_bit%0d", n)));
      else         step(idle_e($sformatf("load_bit%0d", n)));
      if (n == 6)
        for (int g = 0; g < gap_len; g++) begin
          start = 1;
          step(idle_e("load_gap_start"));
        end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] s2;
    rst = 0; clear = 0; key_sin = 0; key_sin_valid = 0; start = 0; stop = 0;
    k0 = 6'b111101;
    k1 = 6'b110010;
    @(negedge clk);

    rst = 1; step(idle_e("reset"));
    rst = 1; step(idle_e("reset2"));

    // Load 1,0,1,1,1,1,0,<gap of 3 with start>,1,0,0,1,1
    load(12'b110010111101, 3);

    // Extra bits in ARMED must not alter the keys; lone stop is ignored.
    for (int i = 0; i < 14; i++) begin
      key_sin = i[0] ^ 1'b1;
      key_sin_valid = 1;
      step(arm_e("armed_extra_bits"));
    end
    stop = 1; step(arm_e("stop_in_armed"));

    // start+stop together in ARMED: start wins.
    start = 1; stop = 1; step(run_e("run_entry", 0, 1'b1));
    for (int c = 1; c <= 16; c++) step(run_e($sformatf("run_c%0d", c), c, 1'b0));

    // Now at cnt=4: stop, wait, restart.
    stop = 1; step(arm_e("stopped"));
    step(arm_e("stopped_idle"));
    start = 1; step(run_e("restart_entry", 0, 1'b1));
    for (int c = 1; c <= 3; c++) step(run_e($sformatf("rerun_c%0d", c), c, 1'b0));

    // start+stop together in RUN: stop wins.
    start = 1; stop = 1; step(arm_e("stop_wins_in_run"));
    start = 1; step(run_e("restart2_entry", 0, 1'b1));
    for (int c = 1; c <= 8; c++) step(run_e($sformatf("rerun2_c%0d", c), c, 1'b0));

    // rst at cnt=8: back to IDLE, start ignored until reload.
    rst = 1; step(idle_e("rst_mid_run"));
    for (int i = 0; i < 3; i++) begin
      start = 1;
      step(idle_e("start_after_rst"));
    end

    // Reload with fresh keys (no gap), run, then zeroize with clear.
    s2 = 12'($urandom);
    k0 = s2[5:0];
    k1 = s2[11:6];
    load(s2, 0);
    start = 1; step(run_e("run2_entry", 0, 1'b1));
    for (int c = 1; c <= 7; c++) step(run_e($sformatf("run2_c%0d", c), c, 1'b0));
    clear = 1; step(idle_e("clear_mid_run"));
    start = 1; step(idle_e("start_after_clear"));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
